// File: rtl/syn_global_pkg.sv
// Shared local-bus definitions: unmapped read pattern and the word-index decode used by
// every cortex sub-block slave.
package syn_global_pkg;

  localparam logic [31:0] LB_UNMAPPED_RDATA = 32'hDEAD_DEAD;

  typedef enum logic [2:0] {
    CFG,
    STATUS,
    EVCNT,
    ERRCNT,
    UNMAPPED
  } lb_idx_e;

  // Classifies a block-local word index; the error-counter slot exists only when enabled.
  function automatic lb_idx_e lb_decode(input int unsigned idx, input int unsigned num_regs,
                                        input bit err_en);
    lb_idx_e kind;
    if (idx < num_regs) begin
      kind = CFG;
    end else if (idx == num_regs) begin
      kind = STATUS;
    end else if (idx == num_regs + 1) begin
      kind = EVCNT;
    end else if (err_en && (idx == num_regs + 2)) begin
      kind = ERRCNT;
    end else begin
      kind = UNMAPPED;
    end
    return kind;
  endfunction

endpackage

// File: rtl/syn_lb_reg_slave_if.sv
// Local-bus request/response bundle between the Avalon-MM bridge (master) and a block slave.
interface syn_lb_reg_slave_if #(
  parameter int unsigned P_LB_DATA_W = 32,
  parameter int unsigned P_LB_ADDR_W = 16
);

  logic                   lb_rd_en_i;
  logic                   lb_wr_en_i;
  logic [P_LB_ADDR_W-1:0] lb_addr_i;
  logic [P_LB_DATA_W-1:0] lb_wr_data_i;
  logic                   lb_rd_valid_o;
  logic [P_LB_DATA_W-1:0] lb_rd_data_o;

  modport master (
    output lb_rd_en_i,
    output lb_wr_en_i,
    output lb_addr_i,
    output lb_wr_data_i,
    input  lb_rd_valid_o,
    input  lb_rd_data_o
  );

  modport slave (
    input  lb_rd_en_i,
    input  lb_wr_en_i,
    input  lb_addr_i,
    input  lb_wr_data_i,
    output lb_rd_valid_o,
    output lb_rd_data_o
  );

endinterface

// File: rtl/syn_lb_rd_pipe.sv
// Fixed-latency {valid, data} delay line for local-bus read returns; data is forced to zero
// in any stage whose valid is low so the output is clean between returns.
module syn_lb_rd_pipe #(
  parameter int unsigned P_DATA_W = 32,
  parameter int unsigned P_DEPTH  = 2
) (
  input  logic                clk_ir,
  input  logic                rst_il,
  input  logic                valid_i,
  input  logic [P_DATA_W-1:0] data_i,
  output logic                valid_o,
  output logic [P_DATA_W-1:0] data_o
);

  logic [P_DEPTH-1:0]  valid_q, valid_d;
  logic [P_DATA_W-1:0] data_q [P_DEPTH];
  logic [P_DATA_W-1:0] data_d [P_DEPTH];

  always_comb begin
    valid_d    = '0;
    data_d     = '{default: '0};
    valid_d[0] = valid_i;
    data_d[0]  = valid_i ? data_i : '0;
    for (int i = 1; i < P_DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q[P_DEPTH-1];
  assign data_o  = data_q[P_DEPTH-1];

endmodule

// File: rtl/syn_lb_reg_slave.sv
// Local-bus register slave: RW config bank, status word, saturating event counter, and an
// optional unmapped-access error counter enabled by SYN_LB_REG_SLAVE_ERR_CNT_EN.
module syn_lb_reg_slave
  import syn_global_pkg::*;
#(
  parameter int unsigned P_LB_DATA_W = 32,
  parameter int unsigned P_LB_ADDR_W = 16,
  parameter logic [3:0]  P_BLK_CODE  = 4'h0,
  parameter int unsigned P_NUM_REGS  = 8,
  parameter int unsigned P_RD_LAT    = 2
) (
  input  logic                              clk_ir,
  input  logic                              rst_il,
  syn_lb_reg_slave_if.slave                 lb,
  output logic [P_NUM_REGS*P_LB_DATA_W-1:0] cfg_regs_o,
  input  logic [P_LB_DATA_W-1:0]            status_i,
  input  logic                              ev_pulse_i
);

  localparam int unsigned IdxW = P_LB_ADDR_W - 4;
`ifdef SYN_LB_REG_SLAVE_ERR_CNT_EN
  localparam bit ErrCntEn = 1'b1;
`else
  localparam bit ErrCntEn = 1'b0;
`endif

  logic            hit, rd_hit, wr_hit;
  logic [IdxW-1:0] idx;
  lb_idx_e         idx_kind;

  assign hit      = (lb.lb_addr_i[P_LB_ADDR_W-1 -: 4] == P_BLK_CODE);
  assign idx      = lb.lb_addr_i[IdxW-1:0];
  assign idx_kind = lb_decode(32'(idx), P_NUM_REGS, ErrCntEn);
  assign rd_hit   = lb.lb_rd_en_i & hit;
  assign wr_hit   = lb.lb_wr_en_i & hit;

  // Config register bank
  logic [P_LB_DATA_W-1:0] cfg_q [P_NUM_REGS];
  logic [P_LB_DATA_W-1:0] cfg_d [P_NUM_REGS];

  always_comb begin
    cfg_d = cfg_q;
    if (wr_hit && (idx_kind == CFG)) begin
      for (int i = 0; i < P_NUM_REGS; i++) begin
        if (idx == IdxW'(i)) cfg_d[i] = lb.lb_wr_data_i;
      end
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      cfg_q <= '{default: '0};
    end else begin
      cfg_q <= cfg_d;
    end
  end

  always_comb begin
    cfg_regs_o = '0;
    for (int i = 0; i < P_NUM_REGS; i++) begin
      cfg_regs_o[i*P_LB_DATA_W +: P_LB_DATA_W] = cfg_q[i];
    end
  end

  // Event counter: clear is applied first so clear+pulse in one cycle lands on 1.
  logic [31:0] ev_cnt_q, ev_cnt_d;

  always_comb begin
    ev_cnt_d = ev_cnt_q;
    if (wr_hit && (idx_kind == EVCNT)) ev_cnt_d = '0;
    if (ev_pulse_i && (ev_cnt_d != '1)) ev_cnt_d = ev_cnt_d + 32'd1;
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      ev_cnt_q <= '0;
    end else begin
      ev_cnt_q <= ev_cnt_d;
    end
  end

  logic [15:0] err_cnt_rd;

`ifdef SYN_LB_REG_SLAVE_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_hit;

  assign err_hit = (rd_hit | wr_hit) & (idx_kind == UNMAPPED);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (wr_hit && (idx_kind == ERRCNT)) err_cnt_d = '0;
    if (err_hit && (err_cnt_d != '1)) err_cnt_d = err_cnt_d + 16'd1;
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_rd = err_cnt_q;
`else
  assign err_cnt_rd = '0;
`endif

  // Read mux samples pre-write state, so a same-cycle read+write returns the old value.
  logic [P_LB_DATA_W-1:0] rd_mux;

  always_comb begin
    rd_mux = P_LB_DATA_W'(LB_UNMAPPED_RDATA);
    unique case (idx_kind)
      CFG: begin
        rd_mux = '0;
        for (int i = 0; i < P_NUM_REGS; i++) begin
          if (idx == IdxW'(i)) rd_mux = cfg_q[i];
        end
      end
      STATUS:  rd_mux = status_i;
      EVCNT:   rd_mux = P_LB_DATA_W'(ev_cnt_q);
      ERRCNT:  rd_mux = P_LB_DATA_W'(err_cnt_rd);
      default: rd_mux = P_LB_DATA_W'(LB_UNMAPPED_RDATA);
    endcase
  end

  syn_lb_rd_pipe #(
    .P_DATA_W (P_LB_DATA_W),
    .P_DEPTH  (P_RD_LAT)
  ) u_rd_pipe (
    .clk_ir  (clk_ir),
    .rst_il  (rst_il),
    .valid_i (rd_hit),
    .data_i  (rd_mux),
    .valid_o (lb.lb_rd_valid_o),
    .data_o  (lb.lb_rd_data_o)
  );

endmodule
